// File: rtl/median_filter_mc.sv
`default_nettype none
// ============================================================================
// Module  : median_filter_mc
// Brief   : Streaming 3x3 window filter (bypass/median/min/max) applied
//           independently to CH packed pixel channels, fixed 4-cycle latency.
// Rev     : 1.0  initial release
// ============================================================================
module median_filter_mc #(
    parameter int DW    = 8,
    parameter int CH    = 1,
    parameter int MAX_W = 1920,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vvalid,
    input  logic             hvalid,
    input  logic [CH*DW-1:0] din,
    input  logic [1:0]       mode,
    output logic             fsync,
    output logic             hsync,
    output logic [CH*DW-1:0] dout,
    output logic             ovf
);

    localparam int PW = CH * DW;
    localparam int CW = AW + 1;
    localparam int RW = 12;

    localparam logic [CW-1:0] C_MAX_W   = CW'(MAX_W);
    localparam logic [CW-1:0] C_COL_ONE = CW'(1);
    localparam logic [CW-1:0] C_COL_TWO = CW'(2);
    localparam logic [RW-1:0] C_ROW_ONE = RW'(1);
    localparam logic [RW-1:0] C_ROW_TWO = RW'(2);
    localparam logic [RW-1:0] C_ROW_SAT = '1;

    localparam logic [1:0] C_MODE_BYPASS = 2'b00;
    localparam logic [1:0] C_MODE_MEDIAN = 2'b01;
    localparam logic [1:0] C_MODE_MIN    = 2'b10;
    localparam logic [1:0] C_MODE_MAX    = 2'b11;

    function automatic logic [DW-1:0] f_min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] f_max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] f_min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        return f_min2(f_min2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] f_max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        return f_max2(f_max2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] f_med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
    endfunction

    // ------------------------------------------------------------------------
    // Framing, counters and control
    // ------------------------------------------------------------------------
    logic          r_vv_d;
    logic          r_hv_d;
    logic          r_run;
    logic          r_ovf;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [1:0]    r_mode_q;

    logic          w_vrise;
    logic          w_act;
    logic          w_acc;
    logic          w_in_rng;
    logic          w_wr;
    logic          w_win_ok;
    logic          w_hfall;
    logic [1:0]    w_mode;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] w_rd0;
    logic [PW-1:0] w_rd1;

    assign w_vrise  = vvalid & ~r_vv_d;
    assign w_act    = vvalid & (r_run | w_vrise);
    assign w_acc    = w_act & hvalid;
    assign w_in_rng = (r_col < C_MAX_W);
    assign w_wr     = w_acc & w_in_rng;
    assign w_win_ok = w_wr & (r_col >= C_COL_TWO) & (r_row >= C_ROW_TWO);
    assign w_hfall  = w_act & r_hv_d & ~hvalid;
    assign w_mode   = w_vrise ? mode : r_mode_q;
    assign w_addr   = r_col[AW-1:0];

    // r_vv_d resets high so a frame already in progress at reset release
    // cannot produce a rising edge; the block waits for vvalid to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vv_d   <= 1'b1;
            r_hv_d   <= 1'b0;
            r_run    <= 1'b0;
            r_ovf    <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_mode_q <= C_MODE_BYPASS;
        end else begin
            r_vv_d <= vvalid;
            r_hv_d <= w_acc;
            r_run  <= w_act;
            if (w_vrise) begin
                r_mode_q <= mode;
            end
            if (w_acc) begin
                if (w_in_rng) begin
                    r_col <= r_col + C_COL_ONE;
                end
            end else begin
                r_col <= '0;
            end
            if (!w_act) begin
                r_row <= '0;
            end else if (w_hfall && (r_row != C_ROW_SAT)) begin
                r_row <= r_row + C_ROW_ONE;
            end
            if (w_acc && !w_in_rng) begin
                r_ovf <= 1'b1;
            end else if (w_vrise) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers: buf0 holds row r-1, buf1 holds row r-2
    // ------------------------------------------------------------------------
    logic [PW-1:0] r_buf0 [MAX_W];
    logic [PW-1:0] r_buf1 [MAX_W];

    assign w_rd0 = r_buf0[w_addr];
    assign w_rd1 = r_buf1[w_addr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf0[w_addr] <= din;
            r_buf1[w_addr] <= w_rd0;
        end
    end

    // ------------------------------------------------------------------------
    // S1 window register and pipeline control
    // ------------------------------------------------------------------------
    logic [2:0][2:0][PW-1:0] r_win;   // [col][row], index 2 is newest
    logic                    r_v1;
    logic                    r_v2;
    logic                    r_v3;
    logic                    r_hsync;
    logic [1:0]              r_m1;
    logic [1:0]              r_m2;
    logic [1:0]              r_m3;
    logic [3:0]              r_fs;
    logic [PW-1:0]           r_dout;
    logic [PW-1:0]           w_res;

    // Mode travels with the data so the tail of one frame is not affected by
    // the mode latched for a back-to-back successor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_hsync <= 1'b0;
            r_m1    <= C_MODE_BYPASS;
            r_m2    <= C_MODE_BYPASS;
            r_m3    <= C_MODE_BYPASS;
            r_fs    <= '0;
            r_dout  <= '0;
        end else begin
            r_v1    <= w_win_ok;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_hsync <= r_v3;
            r_m1    <= w_mode;
            r_m2    <= r_m1;
            r_m3    <= r_m2;
            r_fs    <= {r_fs[2:0], w_act};
            if (w_wr) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= {din, w_rd0, w_rd1};
            end
            if (r_v3) begin
                r_dout <= w_res;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2..S4 per channel sorting network
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [2:0][DW-1:0] r_mn;
        logic [2:0][DW-1:0] r_md;
        logic [2:0][DW-1:0] r_mx;
        logic [DW-1:0]      r_ctr2;
        logic [DW-1:0]      r_a;
        logic [DW-1:0]      r_b;
        logic [DW-1:0]      r_c;
        logic [DW-1:0]      r_gmin;
        logic [DW-1:0]      r_gmax;
        logic [DW-1:0]      r_ctr3;
        logic [DW-1:0]      w_sel;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mn   <= '0;
                r_md   <= '0;
                r_mx   <= '0;
                r_ctr2 <= '0;
                r_a    <= '0;
                r_b    <= '0;
                r_c    <= '0;
                r_gmin <= '0;
                r_gmax <= '0;
                r_ctr3 <= '0;
            end else begin
                for (int j = 0; j < 3; j++) begin
                    r_mn[j] <= f_min3(r_win[j][0][k*DW +: DW], r_win[j][1][k*DW +: DW],
                                      r_win[j][2][k*DW +: DW]);
                    r_md[j] <= f_med3(r_win[j][0][k*DW +: DW], r_win[j][1][k*DW +: DW],
                                      r_win[j][2][k*DW +: DW]);
                    r_mx[j] <= f_max3(r_win[j][0][k*DW +: DW], r_win[j][1][k*DW +: DW],
                                      r_win[j][2][k*DW +: DW]);
                end
                r_ctr2 <= r_win[1][1][k*DW +: DW];
                r_a    <= f_max3(r_mn[0], r_mn[1], r_mn[2]);
                r_b    <= f_med3(r_md[0], r_md[1], r_md[2]);
                r_c    <= f_min3(r_mx[0], r_mx[1], r_mx[2]);
                r_gmin <= f_min3(r_mn[0], r_mn[1], r_mn[2]);
                r_gmax <= f_max3(r_mx[0], r_mx[1], r_mx[2]);
                r_ctr3 <= r_ctr2;
            end
        end

        always_comb begin
            w_sel = r_ctr3;
            case (r_m3)
                C_MODE_MEDIAN: w_sel = f_med3(r_a, r_b, r_c);
                C_MODE_MIN:    w_sel = r_gmin;
                C_MODE_MAX:    w_sel = r_gmax;
                default:       w_sel = r_ctr3;
            endcase
        end

        assign w_res[k*DW +: DW] = w_sel;
    end

    assign fsync = r_fs[3];
    assign hsync = r_hsync;
    assign dout  = r_dout;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/median_filter_mc.md
Name: median_filter_mc

Overview:
Parametrised successor to the single-channel 3x3 median filter. Applies a 3x3 window operator independently to CH packed pixel channels of a streamed frame using vvalid/hvalid framing. Selectable modes: bypass, median, min and max. Line length is programmable up to MAX_W. Sits between the sensor/stimulus source and downstream edge-detection stages; its fsync/hsync/dout outputs feed the frame sink directly.

Parameters:
DW, 8, bits per channel pixel
CH, 1, number of independent channels packed in din/dout (channel k at bits [k*DW +: DW])
MAX_W, 1920, maximum pixels per line; line-buffer depth
AW, 11, line-buffer address width, ceil(log2(MAX_W))

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
vvalid  input  1  frame valid, high for the whole frame
hvalid  input  1  line valid; one pixel accepted per cycle while vvalid&hvalid
din  input  CH*DW  input pixels
mode  input  2  00 bypass, 01 median, 10 min, 11 max
fsync  output  1  vvalid delayed by LAT cycles
hsync  output  1  dout valid strobe
dout  output  CH*DW  filtered pixels
ovf  output  1  sticky: current frame had a line longer than MAX_W

Behaviour:
- Reset: fsync, hsync and ovf = 0; dout = 0; col/row counters = 0; mode_q = 00. Line-buffer contents are don't-care.
- Counters: col increments per accepted pixel and clears when hvalid = 0. row increments on each hvalid falling edge inside vvalid and clears when vvalid = 0.
- Line buffers: two RAMs of CH*DW x MAX_W, addressed by col. Each cycle, buf0 is read and the value written to buf1; din is written to buf0. This forms a 3-row column (row r-2, r-1, r). Two column-shift stages complete the 3x3 window.
- Window valid: accepted pixel with row >= 2, col >= 2, col < MAX_W. The window covers rows r-2..r and cols c-2..c; centre is (r-1, c-1).
- Output geometry: (H-2) x (W-2) pixels per frame. No border padding; the first two rows and columns produce no hsync.
- Latency: LAT = 4 cycles, fixed for all modes. Pixel (r,c) accepted at cycle t produces hsync = 1 at t+4 for window (r,c).
- Pipeline stages:
  - S1: window register.
  - S2: per-column 3-sort.
  - S3: max of column minima, median of column medians, min of column maxima.
  - S4: 3-sort of S3 results; output register.
- Operator per mode:
  - Bypass: dout = centre pixel.
  - Min/max: min/max of all 9 pixels.
  - Arithmetic is unsigned DW-bit compare only; no widening.
- Channels are fully independent; channel k uses only bits [k*DW +: DW].
- dout holds its last value when hsync = 0.
- mode_q latches mode on the vvalid rising edge. Changes to mode mid-frame are ignored until the next frame.
- Overflow: pixels with col >= MAX_W are not written and produce no window. ovf is set when this occurs and clears on the next vvalid rising edge.
- hvalid with vvalid = 0 is ignored. hvalid gaps end the line.
- Asynchronous rst mid-frame: all outputs go to reset values immediately and the pipeline is flushed. The block restarts on the next vvalid rising edge. A vvalid already high at reset release is ignored until it falls.
- Back-to-back frames (vvalid low for 1 cycle) are supported.

Test Plan:
- Bypass, 6-wide x 5-row frame, din = 16*r + c: expect 12 hsync pulses. First dout = 0x11, 4 cycles after pixel (2,2). Last dout = 0x34. fsync equals vvalid delayed 4 cycles.
- Median, frame of 0x40 with 0xFF at (2,2) and 0x00 at (3,3): every dout = 0x40.
- Min and max on the ramp frame from the first test: first dout = 0x00 (min), 0x22 (max). Last dout = 0x23 (min), 0x45 (max).
- CH=3, channel 0 ramp, channel 1 constant 0x7F, channel 2 salt noise on 0x10: channel 0 bypass-equal to median of ramp, channel 1 = 0x7F, channel 2 = 0x10. No cross-channel leakage.
- MAX_W=8, line width 11: ovf = 1 during the frame. Exactly 6 outputs per valid row. ovf clears at the next frame start.
- Reset asserted mid-row 3: hsync/fsync/dout = 0 that cycle. Mode toggled mid-frame has no effect. The next clean frame matches the golden median output bit-exactly.
